// File: rtl/rv32_dbus_adapter.sv
// Data-memory bus adapter: registers rv32_mem load/store requests, runs the valid/ready
// handshake and stalls the pipeline until the response is consumed. Optional watchdog: RV32_DBUS_TIMEOUT_EN.
module rv32_dbus_adapter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce_i,
  input  logic        stall_in,
  input  logic        data_read_in,
  input  logic        data_write_in,
  input  logic [3:0]  data_write_mask_in,
  input  logic [31:0] data_address_in,
  input  logic [31:0] data_write_value_in,
  output logic [31:0] data_read_value_out,
  output logic        data_fault_out,
  output logic        stall_out,
  output logic        bus_valid_out,
  input  logic        bus_ready_in,
  output logic        bus_we_out,
  output logic [31:0] bus_address_out,
  output logic [31:0] bus_write_value_out,
  output logic [3:0]  bus_write_mask_out,
  input  logic        bus_resp_valid_in,
  input  logic [31:0] bus_read_value_in,
  input  logic        bus_error_in
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [3:0]  mask_q, mask_d;
  logic        we_q, we_d;
  logic        fault_q, fault_d;
  logic        req;
  logic        req_ok;

  assign req = data_read_in | data_write_in;

`ifdef RV32_DBUS_TIMEOUT_EN
  logic [31:0] cnt_q, cnt_d;
  logic        orphan_q, orphan_d;
  logic        expired;

  assign expired = (cnt_q >= 32'(TIMEOUT_CYCLES - 1));
  // An abandoned response is still owed by the bus; hold off new requests until it shows up.
  assign req_ok  = !orphan_q;
`else
  logic unused_timeout;

  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign req_ok         = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    mask_d  = mask_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    fault_d = fault_q;
`ifdef RV32_DBUS_TIMEOUT_EN
    cnt_d    = cnt_q;
    orphan_d = orphan_q;
    if (bus_resp_valid_in) orphan_d = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (req) begin
          state_d = REQ;
          addr_d  = data_address_in;
          wdata_d = data_write_value_in;
          mask_d  = data_write_in ? data_write_mask_in : 4'b0000;
          we_d    = data_write_in;
`ifdef RV32_DBUS_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      REQ: begin
        if (bus_ready_in && req_ok) begin
          state_d = WAIT;
`ifdef RV32_DBUS_TIMEOUT_EN
          cnt_d   = cnt_q + 32'd1;
        end else if (expired) begin
          state_d = DONE;
          rdata_d = '0;
          fault_d = 1'b1;
        end else begin
          cnt_d   = cnt_q + 32'd1;
`endif
        end
      end
      WAIT: begin
        if (bus_resp_valid_in) begin
          state_d = DONE;
          rdata_d = bus_read_value_in;
          fault_d = bus_error_in;
`ifdef RV32_DBUS_TIMEOUT_EN
        end else if (expired) begin
          state_d  = DONE;
          rdata_d  = '0;
          fault_d  = 1'b1;
          orphan_d = 1'b1;
        end else begin
          cnt_d    = cnt_q + 32'd1;
`endif
        end
      end
      DONE: begin
        if (!stall_in) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      mask_q   <= '0;
      we_q     <= 1'b0;
      rdata_q  <= '0;
      fault_q  <= 1'b0;
`ifdef RV32_DBUS_TIMEOUT_EN
      cnt_q    <= '0;
      orphan_q <= 1'b0;
`endif
    end else if (ce_i) begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      mask_q   <= mask_d;
      we_q     <= we_d;
      rdata_q  <= rdata_d;
      fault_q  <= fault_d;
`ifdef RV32_DBUS_TIMEOUT_EN
      cnt_q    <= cnt_d;
      orphan_q <= orphan_d;
`endif
    end
  end

  // Outputs are forced low during reset because the state register only clears at the edge.
  assign bus_valid_out       = !reset && (state_q == REQ) && req_ok;
  assign bus_we_out          = bus_valid_out & we_q;
  assign bus_address_out     = bus_valid_out ? addr_q  : '0;
  assign bus_write_value_out = bus_valid_out ? wdata_q : '0;
  assign bus_write_mask_out  = bus_valid_out ? mask_q  : '0;

  assign data_read_value_out = (!reset && state_q == DONE) ? rdata_q : '0;
  assign data_fault_out      = !reset && (state_q == DONE) && fault_q;
  assign stall_out           = !reset && req && (state_q != DONE);
endmodule

// File: tb/tb_rv32_dbus_adapter.sv
// Scoreboard bench for rv32_dbus_adapter: directed transactions against a configurable bus responder.
module tb_rv32_dbus_adapter;
  logic        clk = 1'b0;
  logic        reset, ce_i, stall_in, data_read_in, data_write_in;
  logic [3:0]  data_write_mask_in;
  logic [31:0] data_address_in, data_write_value_in;
  logic [31:0] data_read_value_out;
  logic        data_fault_out, stall_out, bus_valid_out, bus_ready_in, bus_we_out;
  logic [31:0] bus_address_out, bus_write_value_out;
  logic [3:0]  bus_write_mask_out;
  logic        bus_resp_valid_in, bus_error_in;
  logic [31:0] bus_read_value_in;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
  } bus_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        fault;
  } resp_t;

  bus_req_t bus_q[$];
  resp_t    resp_q[$];

  int          ready_dly = 0;
  int          resp_dly  = 0;
  logic [31:0] resp_data = '0;
  logic        resp_err  = 1'b0;

  rv32_dbus_adapter #(.TIMEOUT_CYCLES(8)) dut (
    .clk                 (clk),
    .reset               (reset),
    .ce_i                (ce_i),
    .stall_in            (stall_in),
    .data_read_in        (data_read_in),
    .data_write_in       (data_write_in),
    .data_write_mask_in  (data_write_mask_in),
    .data_address_in     (data_address_in),
    .data_write_value_in (data_write_value_in),
    .data_read_value_out (data_read_value_out),
    .data_fault_out      (data_fault_out),
    .stall_out           (stall_out),
    .bus_valid_out       (bus_valid_out),
    .bus_ready_in        (bus_ready_in),
    .bus_we_out          (bus_we_out),
    .bus_address_out     (bus_address_out),
    .bus_write_value_out (bus_write_value_out),
    .bus_write_mask_out  (bus_write_mask_out),
    .bus_resp_valid_in   (bus_resp_valid_in),
    .bus_read_value_in   (bus_read_value_in),
    .bus_error_in        (bus_error_in)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bus responder: ready after ready_dly REQ cycles, response resp_dly cycles after acceptance.
  initial begin : responder
    int phase;
    int cnt;
    phase = 0;
    cnt   = 0;
    bus_ready_in = 1'b0; bus_resp_valid_in = 1'b0; bus_read_value_in = '0; bus_error_in = 1'b0;
    forever begin
      @(negedge clk);
      bus_ready_in = 1'b0; bus_resp_valid_in = 1'b0; bus_read_value_in = '0; bus_error_in = 1'b0;
      if (phase == 0) begin
        if (bus_valid_out) begin
          if (cnt >= ready_dly) begin
            bus_ready_in = 1'b1; phase = 1; cnt = 0;
          end else cnt++;
        end
      end else begin
        if (cnt >= resp_dly) begin
          bus_resp_valid_in = 1'b1; bus_read_value_in = resp_data; bus_error_in = resp_err;
          phase = 0; cnt = 0;
        end else cnt++;
      end
    end
  end

  // Monitor: samples just before each rising edge.
  initial begin : monitor
    bus_req_t c, pf, e;
    resp_t    r;
    logic     pv, pr, have_hold, hf;
    logic [31:0] hrd;
    pv = 1'b0; pr = 1'b0; have_hold = 1'b0; pf = '0; hf = 1'b0; hrd = '0;
    forever begin
      @(negedge clk); #4;
      c = '{we: bus_we_out, addr: bus_address_out, wdata: bus_write_value_out, mask: bus_write_mask_out};
      if (reset) begin
        check("reset_outputs", {data_read_value_out, data_fault_out, stall_out, bus_valid_out, 128'(c)}, '0);
        pv = 1'b0; have_hold = 1'b0;
      end else begin
        if (pv && !pr && bus_valid_out) check("bus_stable", 128'(c), 128'(pf));
        if (bus_valid_out && bus_ready_in) begin
          if (bus_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL bus_req: unexpected request %0h, none expected", c);
          end else begin
            e = bus_q.pop_front();
            check("bus_req", 128'(c), 128'(e));
          end
        end
        pv = bus_valid_out; pr = bus_ready_in; pf = c;
        if (stall_out) begin
          check("data_zero_outside_done", {data_fault_out, data_read_value_out}, '0);
        end else if (data_read_in || data_write_in) begin
          if (stall_in || !ce_i) begin
            if (!have_hold) begin
              have_hold = 1'b1; hrd = data_read_value_out; hf = data_fault_out;
            end else check("hold_stable", {data_fault_out, data_read_value_out}, {hf, hrd});
          end else begin
            if (resp_q.size() == 0) begin
              n_tests++; n_fail++;
              $display("FAIL resp: unexpected result %0h, none expected", data_read_value_out);
            end else begin
              r = resp_q.pop_front();
              check("resp", {data_fault_out, data_read_value_out}, {r.fault, r.rdata});
            end
            have_hold = 1'b0;
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    data_read_in = 1'b0; data_write_in = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Called at a falling edge; returns at the falling edge after the result was consumed, request still driven.
  task automatic issue(input string name, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] mask, input int rdly, input int sdly, input logic [31:0] rd,
                       input logic er, input logic to, input int hold_stall, input int hold_ce, input int exp_stall);
    int nst, hs, hc;
    logic done;
    bus_q.push_back('{we: we, addr: addr, wdata: wdata, mask: (we ? mask : 4'b0000)});
    resp_q.push_back(to ? '{rdata: 32'h0, fault: 1'b1} : '{rdata: rd, fault: er});
    ready_dly = rdly; resp_dly = sdly; resp_data = rd; resp_err = er;
    data_read_in = !we; data_write_in = we; data_address_in = addr;
    data_write_value_in = wdata; data_write_mask_in = mask;
    nst = 0; hs = 0; hc = 0; done = 1'b0;
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      #1;
      if (stall_out) nst++;
      else if (hs < hold_stall) begin stall_in = 1'b1; hs++; end
      else if (hc < hold_ce) begin stall_in = 1'b0; ce_i = 1'b0; hc++; end
      else begin stall_in = 1'b0; ce_i = 1'b1; done = 1'b1; end
      @(negedge clk);
    end
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL %s_timeout: got no completion, required completion within 300 cycles", name);
      stall_in = 1'b0; ce_i = 1'b1;
    end else check({name, "_stall_cycles"}, 128'(nst), 128'(exp_stall));
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1);
  end

  initial begin : main
    reset = 1'b1; ce_i = 1'b1; stall_in = 1'b0; data_read_in = 1'b0; data_write_in = 1'b0;
    data_write_mask_in = '0; data_address_in = '0; data_write_value_in = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    idle(2);

    issue("zw_load", 1'b0, 32'h0000_1000, 32'h0, 4'hF, 0, 0, 32'hDEAD_BEEF, 1'b0, 1'b0, 0, 0, 3);
    idle(1);
    issue("dly_store", 1'b1, 32'h0000_2004, 32'h0000_ABCD, 4'b0011, 2, 0, 32'h0, 1'b0, 1'b0, 0, 0, 5);
    idle(1);
    issue("err_load", 1'b0, 32'h0000_1004, 32'h0, 4'h0, 0, 1, 32'h0, 1'b1, 1'b0, 0, 0, 4);
    idle(1);
    issue("stall_hold", 1'b0, 32'h0000_1008, 32'h0, 4'h0, 0, 0, 32'hCAFE_F00D, 1'b0, 1'b0, 3, 0, 3);
    idle(1);
    issue("ce_hold", 1'b0, 32'h0000_100C, 32'h0, 4'h0, 0, 2, 32'h2468_ACE0, 1'b0, 1'b0, 0, 2, 5);
    issue("b2b_store", 1'b1, 32'h0000_2008, 32'h1234_0000, 4'b1100, 0, 0, 32'h0, 1'b0, 1'b0, 0, 0, 3);
    issue("b2b_load", 1'b0, 32'h0000_2008, 32'h0, 4'h0, 0, 0, 32'h0BAD_F00D, 1'b0, 1'b0, 0, 0, 3);
    idle(2);

    // Flushed stage: request withdrawn in WAIT, result must be dropped silently.
    ready_dly = 0; resp_dly = 1; resp_data = 32'h7777_7777; resp_err = 1'b0;
    bus_q.push_back('{we: 1'b0, addr: 32'h0000_3000, wdata: 32'h0, mask: 4'b0000});
    data_read_in = 1'b1; data_address_in = 32'h0000_3000; data_write_value_in = '0; data_write_mask_in = '0;
    repeat (2) @(negedge clk);
    idle(6);
    issue("after_flush", 1'b0, 32'h0000_3004, 32'h0, 4'h0, 0, 0, 32'h0F0F_0F0F, 1'b0, 1'b0, 0, 0, 3);
    idle(2);

    // Reset during WAIT, late response must be ignored.
    ready_dly = 0; resp_dly = 4; resp_data = 32'hBAD0_BAD0; resp_err = 1'b1;
    bus_q.push_back('{we: 1'b0, addr: 32'h0000_4000, wdata: 32'h0, mask: 4'b0000});
    data_read_in = 1'b1; data_address_in = 32'h0000_4000;
    repeat (2) @(negedge clk);
    #1 check("wait_stall", 128'(stall_out), 128'(1));
    reset = 1'b1; data_read_in = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (8) begin
      #1 check("post_reset_idle", {bus_valid_out, stall_out, data_fault_out, data_read_value_out}, '0);
      @(negedge clk);
    end
    issue("after_reset", 1'b0, 32'h0000_4004, 32'h0, 4'h0, 0, 0, 32'h1357_9BDF, 1'b0, 1'b0, 0, 0, 3);
    idle(2);

`ifdef RV32_DBUS_TIMEOUT_EN
    issue("timeout", 1'b0, 32'h0000_6000, 32'h0, 4'h0, 0, 30, 32'hFFFF_FFFF, 1'b0, 1'b1, 0, 0, 9);
    idle(30);
    issue("post_timeout", 1'b0, 32'h0000_5000, 32'h0, 4'h0, 0, 0, 32'h0000_0055, 1'b0, 1'b0, 0, 0, 3);
    idle(2);
`endif

    idle(3);
    check("bus_queue_drained", 128'(bus_q.size()), 128'(0));
    check("resp_queue_drained", 128'(resp_q.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
